window_seq_ctrl: RTL and testbench

WINDOW_SEQ_CTRL -- requirements
Module: window_seq_ctrl

---
 rtl/window_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_window_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_seq_ctrl.sv
// Window sequencer: clears the 3x3 window memory, loads one padded frame, then scans it.
// Optional feature: define ABORT_EN to let abort drop an in-flight frame back to idle.
module window_seq_ctrl #(
  parameter int unsigned IMG_W      = 256,
  parameter int unsigned IMG_H      = 32,
  parameter int unsigned LOAD_WORDS = (IMG_W + 2) * (IMG_H + 2)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       mem_rst_n,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic       win_valid,
  output logic [8:0] col_idx,
  output logic [8:0] row_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StScan,
    StFlush,
    StDone
  } state_e;

  state_e      state_q;
  logic        clr_q;
  logic        win_valid_q;
  logic [14:0] load_cnt_q;
  logic [8:0]  nxt_col_q;
  logic [8:0]  nxt_row_q;
  logic [8:0]  col_q;
  logic [8:0]  row_q;

  logic active;
  logic abort_hit;
  logic wr_fire;
  logic rd_fire;
  logic last_wr;
  logic last_rd;
  logic col_wrap;

  assign active = (state_q == StClear) || (state_q == StLoad) ||
                  (state_q == StScan)  || (state_q == StFlush);

`ifdef ABORT_EN
  assign abort_hit = abort && active;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // Strobes are gated by rst_n so they read 0 while reset is held, before the first edge.
  assign in_ready = rst_n && (state_q == StLoad) && !abort_hit;
  assign wr_fire  = in_ready && in_valid;
  assign rd_fire  = rst_n && (state_q == StScan) && out_ready && !abort_hit;

  assign last_wr  = (load_cnt_q == 15'(LOAD_WORDS - 1));
  assign col_wrap = (nxt_col_q == 9'(IMG_W - 1));
  assign last_rd  = col_wrap && (nxt_row_q == 9'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clr_q       <= 1'b0;
      win_valid_q <= 1'b0;
      load_cnt_q  <= '0;
      nxt_col_q   <= '0;
      nxt_row_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      clr_q       <= 1'b0;
      win_valid_q <= rd_fire;
      if (abort_hit) begin
        state_q <= StIdle;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              state_q <= StClear;
              clr_q   <= 1'b1;
            end
          end
          StClear: begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
            nxt_col_q  <= '0;
            nxt_row_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
          end
          StLoad: begin
            if (wr_fire) begin
              load_cnt_q <= load_cnt_q + 15'd1;
              if (last_wr) state_q <= StScan;
            end
          end
          StScan: begin
            if (rd_fire) begin
              // Indices report the read just issued; nxt_* tracks the one to issue next.
              col_q <= nxt_col_q;
              row_q <= nxt_row_q;
              if (col_wrap) begin
                nxt_col_q <= '0;
                nxt_row_q <= nxt_row_q + 9'd1;
              end else begin
                nxt_col_q <= nxt_col_q + 9'd1;
              end
              if (last_rd) state_q <= StFlush;
            end
          end
          StFlush: state_q <= StDone;
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign mem_rst_n = rst_n && !clr_q;
  assign mem_wr    = wr_fire;
  assign mem_rd    = rd_fire;
  assign win_valid = rst_n && win_valid_q;
  assign col_idx   = col_q;
  assign row_idx   = row_q;
  assign busy      = rst_n && active;
  assign done      = rst_n && (state_q == StDone);

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Directed bench for window_seq_ctrl on a 4x2 image (24-word padded frame).
// Build with ABORT_EN defined to exercise the abort path.
module tb_window_seq_ctrl;

  localparam int TW  = 4;
  localparam int TH  = 2;
  localparam int TLW = 24;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_valid, out_ready;
  logic       in_ready, mem_rst_n, mem_wr, mem_rd, win_valid, busy, done;
  logic [8:0] col_idx, row_idx;

  int n_tot = 0;
  int n_bad = 0;
  int writes;
  int reads;

  window_seq_ctrl #(
    .IMG_W     (TW),
    .IMG_H     (TH),
    .LOAD_WORDS(TLW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_ready(out_ready),
    .mem_rst_n(mem_rst_n),
    .mem_wr   (mem_wr),
    .mem_rd   (mem_rd),
    .win_valid(win_valid),
    .col_idx  (col_idx),
    .row_idx  (row_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       in_valid;
    logic       out_ready;
    logic [6:0] exp;  // {in_ready, mem_wr, mem_rd, mem_rst_n, busy, done, win_valid}
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic s, input logic iv, input logic orr, input logic ab);
    @(posedge clk);
    #1;
    start     = s;
    in_valid  = iv;
    out_ready = orr;
    abort     = ab;
    @(negedge clk);
  endtask

  task automatic begin_frame();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clear mem_rst_n", mem_rst_n, 0);
    chk("clear no write", {in_ready, mem_wr}, 0);
    chk("clear busy", busy, 1);
  endtask

  task automatic do_load(input bit gapped, input int already, input int abort_at,
                         output int wr_cnt);
    logic iv, ab;
    int   bad;
    wr_cnt = already;
    bad    = 0;
    for (int c = 0; c < 120; c++) begin
      iv = gapped ? c[0] : 1'b1;
      ab = (abort_at != 0) && (wr_cnt == abort_at - 1) && iv;
      drive(c == 5, iv, 1'b0, ab);
      if (!ab && (in_ready !== 1'b1 || mem_wr !== iv || mem_rst_n !== 1'b1 ||
                  busy !== 1'b1 || mem_rd !== 1'b0)) bad++;
      if (mem_wr === 1'b1) wr_cnt++;
      if (ab || wr_cnt >= TLW) break;
    end
    chk("load handshake", bad, 0);
  endtask

  task automatic check_scan_entry();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    chk("25th pixel refused", {in_ready, mem_wr}, 0);
    chk("scan stall no read", mem_rd, 0);
    chk("scan busy", busy, 1);
  endtask

  task automatic do_scan(input int mode, input int stop_after, output int rd_cnt);
    logic orr, prev_rd;
    int   bad_rd, bad_wv, bad_idx, bad_wr;
    rd_cnt  = 0;
    prev_rd = 1'b0;
    bad_rd  = 0;
    bad_wv  = 0;
    bad_idx = 0;
    bad_wr  = 0;
    for (int c = 0; c < 64; c++) begin
      orr = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      drive(1'b0, 1'b1, orr, 1'b0);
      if (in_ready !== 1'b0 || mem_wr !== 1'b0) bad_wr++;
      if (win_valid !== prev_rd) bad_wv++;
      if (prev_rd && (col_idx !== 9'((rd_cnt - 1) % TW) || row_idx !== 9'((rd_cnt - 1) / TW)))
        bad_idx++;
      if (mem_rd !== orr) bad_rd++;
      prev_rd = mem_rd;
      if (mem_rd === 1'b1) rd_cnt++;
      if (rd_cnt >= stop_after) break;
    end
    chk("scan read count", rd_cnt, stop_after);
    chk("scan mem_rd follows out_ready", bad_rd, 0);
    chk("scan win_valid delay", bad_wv, 0);
    chk("scan indices", bad_idx, 0);
    chk("scan in_valid ignored", bad_wr, 0);
  endtask

  task automatic check_tail();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush no read", mem_rd, 0);
    chk("flush last win_valid", win_valid, 1);
    chk("flush last col", col_idx, TW - 1);
    chk("flush last row", row_idx, TH - 1);
    chk("flush busy/done", {busy, done}, 2'b10);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("done pulse", {busy, done, win_valid, mem_rd}, 4'b0100);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("back to idle", {busy, done, in_ready, mem_rd}, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 7'b0000000};  // in reset
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0001000};  // idle ignores in_valid/out_ready
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b0001000};  // start sampled
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 7'b0000100};  // clear
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b1101100};  // load, write 1
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001100};  // load, gap
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 7'b1101100};  // write 2, start ignored
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b1101100};  // write 3, still loading
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      rst_n     = vecs[i].rst_n;
      start     = vecs[i].start;
      in_valid  = vecs[i].in_valid;
      out_ready = vecs[i].out_ready;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {in_ready, mem_wr, mem_rd, mem_rst_n, busy, done, win_valid}, vecs[i].exp);
    end

    // Frame A: gapped load with a stray start, then out_ready 1,0,0,1.
    do_load(1'b1, 3, 0, writes);
    chk("gapped load writes", writes, TLW);
    check_scan_entry();
    do_scan(1, TW * TH, reads);
    check_tail();

    // Frame B: held load, reset one cycle after the 5th read.
    begin_frame();
    do_load(1'b0, 0, 0, writes);
    chk("held load writes", writes, TLW);
    check_scan_entry();
    do_scan(0, 5, reads);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset outputs", {in_ready, mem_wr, mem_rd, win_valid, busy, done}, 0);
    chk("reset mem_rst_n", mem_rst_n, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset idle", {in_ready, mem_wr, mem_rd, win_valid, busy, done}, 0);
    chk("post-reset indices", {col_idx, row_idx}, 0);
    chk("post-reset mem_rst_n", mem_rst_n, 1);

    // Frame C: full frame after reset.
    begin_frame();
    do_load(1'b0, 0, 0, writes);
    chk("frame C writes", writes, TLW);
    check_scan_entry();
    do_scan(0, TW * TH, reads);
    check_tail();

    // Frame D: abort raised on the 10th write.
    begin_frame();
    do_load(1'b0, 0, 10, writes);
`ifdef ABORT_EN
    chk("abort blocks 10th write", writes, 9);
    begin
      int done_seen;
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      chk("abort to idle", {busy, in_ready, mem_wr, mem_rd, win_valid}, 0);
      done_seen = 0;
      for (int i = 0; i < 4; i++) begin
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      chk("abort no done", done_seen, 0);
    end
`else
    chk("abort ignored write", writes, 10);
    do_load(1'b0, 10, 0, writes);
    chk("abort ignored load", writes, TLW);
    check_scan_entry();
    do_scan(0, TW * TH, reads);
    check_tail();
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
